// File: rtl/ball_handoff_sequencer.sv
// rtl/ball_handoff_sequencer.sv - two-board ball handoff sequencer
//
// Watches the local ball until it leaves the right edge or the local player
// misses, snapshots the ball into the I2C transmit frame, fires the I2C
// master, waits for the ack (with optional resends), then waits for the
// peer's frame and either reloads the ball locally or declares the win.
//
// Optional feature macro: HANDOFF_RETRY_EN (resend on ack timeout, up to
// MAX_RETRY times; without it the first timeout fails the handoff).
//
// Ports:
//   clk_25MHZ, reset_n           clock, asynchronous active-low reset
//   game_start                   level, starts/restarts a match (rising edge aborts)
//   game_over_local              level, local player missed
//   ball_x/ball_y, is_ball_moving_right, ball_vy, gravity_counter, ball_speed
//                                local ball state
//   is_i2c_master_done           pulse, transfer acked
//   rx_valid, slv_reg0..5        pulse + peer frame from the I2C slave
//   ball_send_trigger            pulse, start the I2C master
//   tx_*                         registered transmit frame
//   ball_load, load_*            pulse + received ball state
//   local_ball_active            high in PLAY
//   responsing_i2c               high in SEND and WAIT_ACK
//   is_you_win, send_fail        sticky flags
//   state_dbg                    encoded state
module ball_handoff_sequencer #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int TIMEOUT_CYC = 25000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk_25MHZ,
    input  logic       reset_n,
    input  logic       game_start,
    input  logic       game_over_local,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       is_ball_moving_right,
    input  logic [7:0] ball_vy,
    input  logic [1:0] gravity_counter,
    input  logic [7:0] ball_speed,
    input  logic       is_i2c_master_done,
    input  logic       rx_valid,
    input  logic [7:0] slv_reg0_y0,
    input  logic [7:0] slv_reg1_y1,
    input  logic [7:0] slv_reg2_Yspeed,
    input  logic [7:0] slv_reg3_gravity,
    input  logic [7:0] slv_reg4_ballspeed,
    input  logic [7:0] slv_reg5_win_flag,
    output logic       ball_send_trigger,
    output logic [7:0] tx_y0,
    output logic [7:0] tx_y1,
    output logic [7:0] tx_yspeed,
    output logic [7:0] tx_gravity,
    output logic [7:0] tx_ballspeed,
    output logic [7:0] tx_win_flag,
    output logic       ball_load,
    output logic [9:0] load_y,
    output logic [7:0] load_vy,
    output logic [1:0] load_gravity,
    output logic [7:0] load_speed,
    output logic       local_ball_active,
    output logic       responsing_i2c,
    output logic       is_you_win,
    output logic       send_fail,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY     = 3'd1,
        S_SEND     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_REMOTE   = 3'd4,
        S_LOAD     = 3'd5,
        S_WIN      = 3'd6
    } state_t;

    localparam logic [9:0]  EXIT_X       = 10'(SCREEN_W - 1);
    localparam logic [9:0]  Y_MAX        = 10'(SCREEN_H - 1);
    localparam logic [14:0] TIMEOUT_LAST = 15'(TIMEOUT_CYC - 1);

    state_t      state, next_state;
    logic        game_start_q;
    logic        loss_flag;
    logic [14:0] timeout_cnt;
    logic        start_rise, exit_hit, timeout_hit, retry_left;
    logic        trigger_d, responsing_d, active_d, load_d;
    logic [9:0]  rx_y;

    // Only the low two bits of these peer registers carry information.
    wire unused_rx_bits = &{1'b0, slv_reg1_y1[7:2], slv_reg3_gravity[7:2]};

    assign start_rise  = game_start && !game_start_q;
    assign exit_hit    = is_ball_moving_right && (ball_x >= EXIT_X);
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign rx_y        = {slv_reg1_y1[1:0], slv_reg0_y0};

`ifdef HANDOFF_RETRY_EN
    logic [1:0] retry_cnt;

    assign retry_left = (retry_cnt < 2'(MAX_RETRY));

    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt <= 2'd0;
        end else if (next_state == S_PLAY) begin
            retry_cnt <= 2'd0;
        end else if (state == S_WAIT_ACK && next_state == S_SEND) begin
            retry_cnt <= retry_cnt + 2'd1;
        end
    end
`else
    // No resend hardware: always false for any legal MAX_RETRY.
    assign retry_left = (MAX_RETRY < 0);
`endif

    // State register
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // Next-state logic; a restart edge outranks everything else in the
    // active states, and a miss outranks an exit.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (game_start) next_state = S_PLAY;
            S_PLAY: begin
                if (start_rise)                        next_state = S_IDLE;
                else if (game_over_local || exit_hit)  next_state = S_SEND;
            end
            S_SEND:     next_state = start_rise ? S_IDLE : S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (start_rise)              next_state = S_IDLE;
                else if (is_i2c_master_done) next_state = loss_flag ? S_IDLE : S_REMOTE;
                else if (timeout_hit)        next_state = retry_left ? S_SEND : S_IDLE;
            end
            S_REMOTE: begin
                if (start_rise)    next_state = S_IDLE;
                else if (rx_valid) next_state = (slv_reg5_win_flag != 8'd0) ? S_WIN : S_LOAD;
            end
            S_LOAD:     next_state = start_rise ? S_IDLE : S_PLAY;
            S_WIN:      if (game_start) next_state = S_PLAY;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output decode; the values are registered below so every output is a flop.
    always_comb begin
        trigger_d    = (next_state == S_SEND);
        responsing_d = (next_state == S_SEND) || (next_state == S_WAIT_ACK);
        active_d     = (next_state == S_PLAY);
        load_d       = (state == S_LOAD) && (next_state == S_PLAY);
    end

    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            ball_send_trigger <= 1'b0;
            responsing_i2c    <= 1'b0;
            local_ball_active <= 1'b0;
            ball_load         <= 1'b0;
            state_dbg         <= 3'd0;
        end else begin
            ball_send_trigger <= trigger_d;
            responsing_i2c    <= responsing_d;
            local_ball_active <= active_d;
            ball_load         <= load_d;
            state_dbg         <= next_state;
        end
    end

    // Frames, timeout counter and sticky flags
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            game_start_q <= 1'b0;
            loss_flag    <= 1'b0;
            timeout_cnt  <= 15'd0;
            is_you_win   <= 1'b0;
            send_fail    <= 1'b0;
            tx_y0        <= 8'd0;
            tx_y1        <= 8'd0;
            tx_yspeed    <= 8'd0;
            tx_gravity   <= 8'd0;
            tx_ballspeed <= 8'd0;
            tx_win_flag  <= 8'd0;
            load_y       <= 10'd0;
            load_vy      <= 8'd0;
            load_gravity <= 2'd0;
            load_speed   <= 8'd0;
        end else begin
            game_start_q <= game_start;

            if (next_state == S_PLAY && (state == S_IDLE || state == S_WIN)) begin
                is_you_win <= 1'b0;
                send_fail  <= 1'b0;
                loss_flag  <= 1'b0;
            end

            if (state == S_PLAY && next_state == S_SEND) begin
                loss_flag    <= game_over_local;
                tx_win_flag  <= game_over_local ? 8'h01 : 8'h00;
                tx_y0        <= ball_y[7:0];
                tx_y1        <= {6'b0, ball_y[9:8]};
                tx_yspeed    <= ball_vy;
                tx_gravity   <= {6'b0, gravity_counter};
                tx_ballspeed <= ball_speed;
            end

            if (state == S_SEND) begin
                timeout_cnt <= 15'd0;
            end else if (state == S_WAIT_ACK && timeout_cnt != 15'h7FFF) begin
                timeout_cnt <= timeout_cnt + 15'd1;
            end

            if (state == S_WAIT_ACK && !start_rise && !is_i2c_master_done
                && timeout_hit && !retry_left) begin
                send_fail <= 1'b1;
            end

            if (state == S_REMOTE && !start_rise && rx_valid) begin
                if (slv_reg5_win_flag != 8'd0) begin
                    is_you_win <= 1'b1;
                end else begin
                    load_y       <= (rx_y > Y_MAX) ? Y_MAX : rx_y;
                    load_vy      <= slv_reg2_Yspeed;
                    load_gravity <= slv_reg3_gravity[1:0];
                    load_speed   <= slv_reg4_ballspeed;
                end
            end
        end
    end

endmodule
